// File: rtl/eor_seq_unit_if.sv
// Operand/result handshake bundle for eor_seq_unit.
// master: issue side drives operands and out_ready; slave: the unit.
interface eor_seq_unit_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/eor_seq_unit.sv
// Slice-serial 32-bit XOR unit: accepts (a,b), XORs one SLICE_W slice per
// cycle LSB first, then presents the result on a valid/ready handshake.
// Ports: clk, reset_n (sync, active-low), bus (eor_seq_unit_if.slave),
// busy; out_zero/out_neg only when EOR_SEQ_FLAGS_EN is defined.
// SLICE_W must divide DATA_W.
module eor_seq_unit #(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 8
) (
   input  logic clk,
   input  logic reset_n,
   eor_seq_unit_if.slave bus,
   output logic busy
`ifdef EOR_SEQ_FLAGS_EN
   ,
   output logic out_zero,
   output logic out_neg
`endif
);

   localparam int N  = DATA_W / SLICE_W;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [KW-1:0]     k_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res_q;
   logic [DATA_W-1:0] res_nxt;
   logic              last;

   // result with the current slice k filled in
   always_comb begin
      res_nxt = res_q;
      for (int i = 0; i < N; i++) begin
         if (k_q == KW'(i)) begin
            res_nxt[i*SLICE_W +: SLICE_W] =
               a_q[i*SLICE_W +: SLICE_W] ^ b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   assign last = (k_q == KW'(N - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
`ifdef EOR_SEQ_FLAGS_EN
         out_zero <= 1'b1;
         out_neg  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.in_a;
                  b_q     <= bus.in_b;
                  res_q   <= '0;
                  k_q     <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               res_q <= res_nxt;
               // k saturates at N-1; it is cleared on the next accept
               if (last) begin
                  state_q  <= DONE;
`ifdef EOR_SEQ_FLAGS_EN
                  out_zero <= (res_nxt == '0);
                  out_neg  <= res_nxt[DATA_W-1];
`endif
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = res_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_eor_seq_unit.sv
// Directed self-checking bench for eor_seq_unit.
// Define EOR_SEQ_FLAGS_EN to also check out_zero/out_neg.
module tb_eor_seq_unit;

   logic clk;
   logic reset_n;
   logic busy;
`ifdef EOR_SEQ_FLAGS_EN
   logic out_zero;
   logic out_neg;
`endif

   int checks;
   int failures;
   int lat;
   int nvalid;
   logic [31:0] held;

   eor_seq_unit_if #(.DATA_W(32)) bus ();

   eor_seq_unit #(
      .DATA_W  (32),
      .SLICE_W (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .busy     (busy)
`ifdef EOR_SEQ_FLAGS_EN
      ,
      .out_zero (out_zero),
      .out_neg  (out_neg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // accept one op, return cycles until out_valid (bounded)
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output int l);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      l = 1;
      while (!bus.out_valid && l < 20) begin
         step();
         l++;
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", bus.out_result, 32'h0);
`ifdef EOR_SEQ_FLAGS_EN
      check("rst_zero", 32'(out_zero), 32'd1);
      check("rst_neg", 32'(out_neg), 32'd0);
`endif
      reset_n = 1'b1;
      step();

      // basic op
      do_op(32'd11, 32'd1, lat);
      check("basic_lat", 32'(lat), 32'd5);
      check("basic_res", bus.out_result, 32'h0000000A);
      check("basic_inrdy_done", 32'(bus.in_ready), 32'd0);
      step();
      check("basic_inrdy_back", 32'(bus.in_ready), 32'd1);
      check("basic_ov_pulse", 32'(bus.out_valid), 32'd0);

      // full width, with partial-progress view
      bus.in_a     = 32'hFFFFFFFF;
      bus.in_b     = 32'h075BCD15;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("fw_busy", 32'(busy), 32'd1);
      check("fw_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("fw_partial", bus.out_result, 32'h000000EA);
      lat = 2;
      while (!bus.out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("fw_lat", 32'(lat), 32'd5);
      check("fw_res", bus.out_result, 32'hF8A432EA);
`ifdef EOR_SEQ_FLAGS_EN
      check("fw_neg", 32'(out_neg), 32'd1);
      check("fw_zero", 32'(out_zero), 32'd0);
`endif
      step();
`ifdef EOR_SEQ_FLAGS_EN
      check("fw_neg_idle_hold", 32'(out_neg), 32'd1);
`endif

      // equal operands
      do_op(32'd23, 32'd23, lat);
      check("eq_lat", 32'(lat), 32'd5);
      check("eq_res", bus.out_result, 32'h0);
`ifdef EOR_SEQ_FLAGS_EN
      check("eq_zero", 32'(out_zero), 32'd1);
      check("eq_neg", 32'(out_neg), 32'd0);
`endif
      step();

      // backpressure
      bus.out_ready = 1'b0;
      do_op(32'd6, 32'd9, lat);
      check("bp_lat", 32'(lat), 32'd5);
      check("bp_res", bus.out_result, 32'h0000000F);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check("bp_hold_res", bus.out_result, 32'h0000000F);
         check("bp_hold_inrdy", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_xfer_valid", 32'(bus.out_valid), 32'd0);
      check("bp_xfer_inrdy", 32'(bus.in_ready), 32'd1);

      // mid-operation reset
      bus.in_a     = 32'd101;
      bus.in_b     = 32'd1001;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("mr_valid", 32'(bus.out_valid), 32'd0);
      check("mr_res", bus.out_result, 32'h0);
      check("mr_inrdy", 32'(bus.in_ready), 32'd1);
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.out_valid) nvalid++;
      end
      check("mr_no_result", 32'(nvalid), 32'd0);
      do_op(32'd0, 32'd2, lat);
      check("mr_next_lat", 32'(lat), 32'd5);
      check("mr_next_res", bus.out_result, 32'h00000002);
      step();

      // ignored inputs during BUSY
      bus.in_a     = 32'h000000DC;
      bus.in_b     = 32'h00000EED;
      bus.in_valid = 1'b1;
      step();
      bus.in_a     = 32'hDEADBEEF;
      bus.in_b     = 32'h12345678;
      step();
      bus.in_a     = 32'hFFFF0000;
      bus.in_valid = 1'b0;
      nvalid = 0;
      held   = '0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.out_valid) begin
            nvalid++;
            held = bus.out_result;
         end
      end
      check("ign_res", held, 32'h00000E31);
      check("ign_one_txn", 32'(nvalid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eor_seq_unit.md
# eor_seq_unit

Multi-cycle, handshaked 32-bit exclusive-OR execution unit for the 32-bit ALU. It accepts an operand pair from the issue side over a valid/ready handshake and computes the XOR one slice per cycle, least-significant slice first. It then presents the result over a second valid/ready handshake. It is the responder counterpart to the operand-driving side of the EOR datapath and serves as the template for slice-serial ALU units on area-constrained builds.

## Interface
- DATA_W, 32, operand/result width.
- SLICE_W, 8, bits processed per cycle; must divide DATA_W. N = DATA_W/SLICE_W, default 4.

- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  unit can accept operands.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_W  in_a ^ in_b.
- busy  out  1  high while in BUSY or DONE.
- out_zero  out  1  result == 0 (only with EOR_SEQ_FLAGS_EN).
- out_neg  out  1  result[DATA_W-1] (only with EOR_SEQ_FLAGS_EN).

## Operation
- States are IDLE, BUSY and DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = !IDLE.
- **IDLE:** when in_valid && in_ready, latch in_a and in_b, clear the result register, set slice counter k = 0, and go to BUSY.
- **BUSY:** each cycle, result[k*SLICE_W +: SLICE_W] <= a_slice ^ b_slice, then k increments. After slice k = N-1 is written, go to DONE. The counter does not wrap.
- **DONE:** out_result is held stable. When out_ready is high, go to IDLE.
- Operand inputs are ignored outside the IDLE accept cycle. Changes to in_a/in_b during BUSY have no effect.
- in_ready is low in DONE, so a new accept cannot overlap a result handshake. Minimum initiation interval is N+2 cycles.
- out_result reflects partial progress during BUSY: low slices are done, high slices are zero. Consumers must sample it only on out_valid.
- **Reset (reset_n low at an edge):**
  - state = IDLE, k = 0, out_result = 0.
  - out_valid = 0, busy = 0, in_ready = 1 after the edge.
  - out_zero = 1, out_neg = 0.
  - Reset mid-BUSY or in DONE discards the operation with no result handshake. in_valid is ignored on the reset edge.

## Timing
- Accept in cycle T (in_valid && in_ready sampled high).
- BUSY covers cycles T+1 .. T+N; slice k is written at the end of cycle T+1+k.
- out_valid rises in cycle T+N+1, which is latency N+1 (5 at default).
- Result transfer happens in the first cycle at or after T+N+1 with out_ready high. in_ready rises the next cycle.
- With out_ready held high, out_valid is a single-cycle pulse.
- out_valid, out_result and the flags stay constant while out_valid && !out_ready.

## Configuration
- **EOR_SEQ_FLAGS_EN defined:**
  - out_zero and out_neg exist.
  - They are registered and updated together with the final slice write, so they are valid with out_valid.
  - They hold in DONE. In IDLE they keep the last values, or the reset values.
- **Not defined:** the ports and flag logic are absent, and all other behaviour is identical.

## Test plan
- **Basic op:** after reset, in_a=11, in_b=1 accepted at T -> out_valid at T+5, out_result=0x0000000A; in_ready returns at T+6 with out_ready high.
- **Full-width / flags:** in_a=0xFFFFFFFF, in_b=0x075BCD15 -> out_result=0xF8A432EA; with EOR_SEQ_FLAGS_EN, out_neg=1 and out_zero=0.
- **Equal operands:** in_a=in_b=23 -> out_result=0; out_zero=1, out_neg=0.
- **Backpressure:** in_a=6, in_b=9 with out_ready low for 3 cycles after out_valid rises -> out_result=0x0000000F held stable, in_ready stays 0; transfer occurs on the first out_ready high cycle.
- **Mid-operation reset:** accept in_a=101, in_b=1001; assert reset_n low at T+2 -> next cycle out_valid=0, out_result=0, in_ready=1, and no result is ever presented. A subsequent op with in_a=0, in_b=2 yields 0x00000002 at latency 5.
- **Ignored inputs:** accept in_a=0xDC, in_b=0xEED, then change in_a/in_b and pulse in_valid during BUSY -> result=0x00000E31, and exactly one output transaction occurs.
